// File: rtl/logic_bist.sv
// Exhaustive self-test engine for a WIDTH-bit opcode-selected logic unit.
// Sweeps op/a/b, compares latency-aligned results to a golden model, reports errors.
module logic_bist #(
  parameter int WIDTH   = 4,
  parameter int DUT_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [2:0]       op_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             vec_valid,
  input  logic [WIDTH-1:0] dut_result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       fail_op,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic             vld;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  localparam logic [2:0] LAST_DRAIN = 3'(DUT_LAT - 1);

  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_drain_cnt;
  logic [CNT_W-1:0] r_err_count;
  logic [2:0]       r_fail_op;
  logic [WIDTH-1:0] r_fail_a, r_fail_b;
  logic             r_fail_seen;
  logic             w_start_acc, w_last, w_mismatch;
  vec_t             w_cur, w_cmp;

  function automatic logic [WIDTH-1:0] golden(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  assign w_start_acc = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last      = (r_op == 3'd6) && (&r_a) && (&r_b);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    vec_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    op_out    = 3'd0;
    a_out     = '0;
    b_out     = '0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN: begin
        vec_valid = 1'b1;
        busy      = 1'b1;
        op_out    = r_op;
        a_out     = r_a;
        b_out     = r_b;
        if (w_last) w_next = (DUT_LAT > 0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_drain_cnt == LAST_DRAIN) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_RUN;
      end
      default: w_next = S_IDLE;
    endcase
    pass = done && (r_err_count == '0);
  end

  // Vector generator: b inner, a middle, op outer.
  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      r_op <= 3'd0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (r_state == S_RUN) begin
      r_b <= r_b + 1'b1;
      if (&r_b) begin
        r_a <= r_a + 1'b1;
        if (&r_a) r_op <= w_last ? 3'd0 : r_op + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || r_state != S_DRAIN) r_drain_cnt <= 3'd0;
    else                             r_drain_cnt <= r_drain_cnt + 3'd1;
  end

  assign w_cur = '{vld: vec_valid, op: op_out, a: a_out, b: b_out,
                   exp: golden(op_out, a_out, b_out)};

  generate
    if (DUT_LAT == 0) begin : g_bypass
      assign w_cmp = w_cur;
    end else begin : g_pipe
      vec_t r_pipe [DUT_LAT];
      // NOTE: only the valid bits need a reset; payload is ignored while invalid,
      // so the storage array stays reset-free.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DUT_LAT; i++) r_pipe[i].vld <= 1'b0;
        end else begin
          r_pipe[0] <= w_cur;
          for (int i = 1; i < DUT_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_cmp = r_pipe[DUT_LAT-1];
    end
  endgenerate

  assign w_mismatch = w_cmp.vld && (dut_result != w_cmp.exp);

  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      r_err_count <= '0;
      r_fail_op   <= 3'd0;
      r_fail_a    <= '0;
      r_fail_b    <= '0;
      r_fail_seen <= 1'b0;
    end else if (w_mismatch) begin
      if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
      if (!r_fail_seen) begin
        r_fail_op   <= w_cmp.op;
        r_fail_a    <= w_cmp.a;
        r_fail_b    <= w_cmp.b;
        r_fail_seen <= 1'b1;
      end
    end
  end

  assign err_count = r_err_count;
  assign fail_op   = r_fail_op;
  assign fail_a    = r_fail_a;
  assign fail_b    = r_fail_b;

endmodule
